// File: rtl/cluster_tile_pwr_seq_pkg.sv
// ----------------------------------------------------------------------------
// cluster_tile_pwr_seq_pkg
//
// Shared definitions for the cluster tile clock/reset sequencer: the FSM state
// codes, the per-state tile output encoding and a small helper for sizing the
// sequencer counters. The SoC control-register block and verification
// collateral import this package so that all agree on the state codes
// exposed on the debug port.
// ----------------------------------------------------------------------------
package cluster_tile_pwr_seq_pkg;

    localparam int StateWidth = 3;

    localparam logic [StateWidth-1:0] ST_OFF      = 3'd0;
    localparam logic [StateWidth-1:0] ST_PU_HOLD  = 3'd1;
    localparam logic [StateWidth-1:0] ST_ON       = 3'd2;
    localparam logic [StateWidth-1:0] ST_PD_DRAIN = 3'd3;
    localparam logic [StateWidth-1:0] ST_PD_RST   = 3'd4;
    localparam logic [StateWidth-1:0] ST_PD_GATE  = 3'd5;

    // Registered tile-facing outputs, one bundle per state.
    typedef struct packed {
        logic clk_en;  // tile clock-gate enable
        logic rst_n;   // tile reset, active-low
        logic on;      // tile fully powered and out of reset
        logic busy;    // a sequence is in progress
    } tile_out_t;

    // Output encoding per state. Unknown codes map to the safe OFF encoding
    // (clock gated, reset held).
    function automatic tile_out_t state_outputs(input logic [StateWidth-1:0] st);
        tile_out_t o;
        o = '0;
        case (st)
            ST_OFF:      o = '{clk_en: 1'b0, rst_n: 1'b0, on: 1'b0, busy: 1'b0};
            ST_PU_HOLD:  o = '{clk_en: 1'b1, rst_n: 1'b0, on: 1'b0, busy: 1'b1};
            ST_ON:       o = '{clk_en: 1'b1, rst_n: 1'b1, on: 1'b1, busy: 1'b0};
            ST_PD_DRAIN: o = '{clk_en: 1'b1, rst_n: 1'b1, on: 1'b1, busy: 1'b1};
            ST_PD_RST:   o = '{clk_en: 1'b1, rst_n: 1'b0, on: 1'b0, busy: 1'b1};
            ST_PD_GATE:  o = '{clk_en: 1'b0, rst_n: 1'b0, on: 1'b0, busy: 1'b1};
            default:     o = '0;
        endcase
        return o;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cluster_tile_pwr_seq_if.sv
// ----------------------------------------------------------------------------
// cluster_tile_pwr_seq_if
//
// Command channel from the SoC control registers to the tile sequencer.
//   cmd_valid : command present (driven by master)
//   cmd_on    : requested tile state, 1 = on, 0 = off (driven by master)
//   cmd_ready : sequencer can take a command (driven by slave)
//
// Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready.
// Once cmd_valid is raised the master holds it and cmd_on stable until the
// transfer; cmd_ready may depend combinationally on slave state but never on
// cmd_valid.
// ----------------------------------------------------------------------------
interface cluster_tile_pwr_seq_if;
    logic cmd_valid;
    logic cmd_ready;
    logic cmd_on;

    modport master (output cmd_valid, output cmd_on, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_on, output cmd_ready);
endinterface

// File: rtl/cluster_tile_pwr_seq.sv
// ----------------------------------------------------------------------------
// cluster_tile_pwr_seq
//
// Clock-enable and reset sequencer for one cluster tile. Power-up runs the
// tile clock with reset held for RstHoldCycles, then releases reset.
// Power-down waits for IdleStableCycles consecutive idle cycles (or a forced
// drain timeout), holds reset with the clock running for RstHoldCycles,
// gates the clock for one cycle and settles in OFF.
//
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   cmd             : command channel (slave modport), see the interface
//   idle_i          : tile quiescent, only looked at while draining
//   tile_clk_en_o   : tile clock-gate enable
//   tile_rst_no     : tile reset, active-low
//   tile_on_o       : tile fully powered and out of reset
//   busy_o          : sequence in progress
//   done_o          : one-cycle pulse when a sequence completes
//   timeout_o       : sticky drain-timeout flag
//   timeout_clr_i   : clears timeout_o (a same-cycle set wins)
//   state_o         : current FSM state code (debug)
// ----------------------------------------------------------------------------
module cluster_tile_pwr_seq
    import cluster_tile_pwr_seq_pkg::*;
#(
    parameter int RstHoldCycles    = 4,
    parameter int IdleStableCycles = 8,
    parameter int DrainTimeout     = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cluster_tile_pwr_seq_if.slave       cmd,
    input  logic                        idle_i,
    output logic                        tile_clk_en_o,
    output logic                        tile_rst_no,
    output logic                        tile_on_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        timeout_o,
    input  logic                        timeout_clr_i,
    output logic [StateWidth-1:0]       state_o
);

    localparam int CntWidth = $clog2(max3(RstHoldCycles, IdleStableCycles, DrainTimeout) + 1);

    // Terminal values: a counter equal to N-1 in the current cycle means this
    // is the N-th cycle of the phase.
    localparam logic [CntWidth-1:0] HoldLast = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleStableCycles - 1);
    localparam logic [CntWidth-1:0] TmoLast  = CntWidth'(DrainTimeout - 1);
    localparam logic [CntWidth-1:0] CntMax   = '1;

    logic [StateWidth-1:0] state_q, state_d;
    // Shared phase counter: reset-hold length in PU_HOLD / PD_RST, drain
    // timeout in PD_DRAIN. The phases never overlap.
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [CntWidth-1:0]   idle_cnt_q, idle_cnt_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    tile_out_t             out_q, out_d;

    logic                  cmd_ready;
    logic                  cmd_accept;
    logic                  tmo_set;
    logic [CntWidth-1:0]   cnt_inc;
    logic [CntWidth-1:0]   idle_cnt_inc;

    assign cmd_ready     = (state_q == ST_OFF) || (state_q == ST_ON);
    assign cmd.cmd_ready = cmd_ready;
    assign cmd_accept    = cmd.cmd_valid && cmd_ready;

    // Saturating increments.
    assign cnt_inc      = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);
    assign idle_cnt_inc = (idle_cnt_q == CntMax) ? idle_cnt_q : idle_cnt_q + CntWidth'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idle_cnt_d = idle_cnt_q;
        done_d     = 1'b0;
        tmo_set    = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (cmd_accept && cmd.cmd_on) begin
                    state_d = ST_PU_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_PU_HOLD: begin
                if (cnt_q == HoldLast) begin
                    state_d = ST_ON;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ON: begin
                if (cmd_accept && !cmd.cmd_on) begin
                    state_d    = ST_PD_DRAIN;
                    cnt_d      = '0;
                    idle_cnt_d = '0;
                end
            end
            ST_PD_DRAIN: begin
                cnt_d      = cnt_inc;
                idle_cnt_d = idle_i ? idle_cnt_inc : '0;
                // Idle completion is checked first so it wins a tie with
                // the timeout and leaves the timeout flag untouched.
                if (idle_i && (idle_cnt_q == IdleLast)) begin
                    state_d = ST_PD_RST;
                    cnt_d   = '0;
                end else if (cnt_q == TmoLast) begin
                    state_d = ST_PD_RST;
                    cnt_d   = '0;
                    tmo_set = 1'b1;
                end
            end
            ST_PD_RST: begin
                if (cnt_q == HoldLast) begin
                    state_d = ST_PD_GATE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PD_GATE: begin
                state_d = ST_OFF;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        if (tmo_set) begin
            timeout_d = 1'b1;
        end else if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        out_d = state_outputs(state_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            out_q      <= out_d;
        end
    end

    assign tile_clk_en_o = out_q.clk_en;
    assign tile_rst_no   = out_q.rst_n;
    assign tile_on_o     = out_q.on;
    assign busy_o        = out_q.busy;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_cluster_tile_pwr_seq.sv
// ----------------------------------------------------------------------------
// tb_cluster_tile_pwr_seq
//
// Directed scenarios followed by randomized command/idle traffic. Expected
// outputs come from a phase model: each phase has a fixed output tuple, and
// phase lengths are computed from the idle pattern (first run of IDLE_N
// consecutive idle cycles, else the drain timeout).
// ----------------------------------------------------------------------------
module tb_cluster_tile_pwr_seq;

    localparam int HOLD   = 4;
    localparam int IDLE_N = 8;
    localparam int TMO    = 16;

    localparam int P_OFF  = 0;
    localparam int P_PU   = 1;
    localparam int P_ON   = 2;
    localparam int P_DR   = 3;
    localparam int P_RST  = 4;
    localparam int P_GATE = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       idle;
    logic       clr;
    logic       clk_en, rst_n, tile_on, busy, done, tmo;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    bit tmo_exp = 1'b0;

    always #5 clk = ~clk;

    cluster_tile_pwr_seq_if cmd_if ();

    cluster_tile_pwr_seq #(
        .RstHoldCycles    (HOLD),
        .IdleStableCycles (IDLE_N),
        .DrainTimeout     (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd           (cmd_if),
        .idle_i        (idle),
        .tile_clk_en_o (clk_en),
        .tile_rst_no   (rst_n),
        .tile_on_o     (tile_on),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_o     (tmo),
        .timeout_clr_i (clr),
        .state_o       (state_dbg)
    );

    // {clk_en, rst_n, on, busy} for each phase.
    function automatic logic [3:0] phase_outs(input int p);
        case (p)
            P_OFF:   return 4'b0000;
            P_PU:    return 4'b1001;
            P_ON:    return 4'b1110;
            P_DR:    return 4'b1111;
            P_RST:   return 4'b1001;
            P_GATE:  return 4'b0001;
            default: return 4'bxxxx;
        endcase
    endfunction

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int p, input logic exp_done);
        logic [6:0] obs;
        logic [6:0] exp;
        exp = {phase_outs(p), exp_done, tmo_exp, ((p == P_OFF) || (p == P_ON))};
        obs = {clk_en, rst_n, tile_on, busy, done, tmo, cmd_if.cmd_ready};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%b exp=%b (clk_en,rst_n,on,busy,done,timeout,ready)", tag, obs, exp);
        end
    endtask

    // n cycles in one phase; idle is don't-care outside drain, so randomize it.
    task automatic span(input string tag, input int p, input int n, input bit first_done);
        for (int i = 0; i < n; i++) begin
            idle = 1'($urandom_range(0, 1));
            chk(tag, p, first_done && (i == 0));
            tick();
        end
    endtask

    task automatic power_up();
        chk("pu_pre", P_OFF, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_on    = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        span("pu_hold", P_PU, HOLD, 1'b0);
        span("pu_on", P_ON, 1, 1'b1);
    endtask

    task automatic noop(input int p);
        chk("noop_pre", p, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_on    = (p == P_ON);
        tick();
        cmd_if.cmd_valid = 1'b0;
        span("noop", p, 2, 1'b0);
    endtask

    task automatic pd_accept();
        chk("pd_pre", P_ON, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_on    = 1'b0;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Drain using idle pattern pat (bit k = idle in drain cycle k), then the
    // reset/gate tail. clr_last pulses the clear in the final drain cycle,
    // clr_rst in the first PD_RST cycle.
    task automatic pd_rest(input logic [15:0] pat, input bit clr_last, input bit clr_rst);
        int run;
        int d;
        bit hit_tmo;
        run     = 0;
        d       = TMO;
        hit_tmo = 1'b1;
        for (int k = 0; k < TMO; k++) begin
            run = pat[k] ? run + 1 : 0;
            if (run == IDLE_N) begin
                d       = k + 1;
                hit_tmo = 1'b0;
                break;
            end
        end
        for (int k = 0; k < d; k++) begin
            idle = pat[k];
            clr  = clr_last && (k == d - 1);
            chk("pd_drain", P_DR, 1'b0);
            tick();
        end
        if (hit_tmo) tmo_exp = 1'b1;
        else if (clr_last) tmo_exp = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            idle = 1'($urandom_range(0, 1));
            clr  = clr_rst && (i == 0);
            chk("pd_rst", P_RST, 1'b0);
            tick();
            if (clr) tmo_exp = 1'b0;
        end
        clr = 1'b0;
        span("pd_gate", P_GATE, 1, 1'b0);
        span("pd_off", P_OFF, 1, 1'b1);
    endtask

    initial begin
        bit          cur_on;
        logic [15:0] pat;
        int          thr;

        rst              = 1'b1;
        idle             = 1'b0;
        clr              = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_on    = 1'b0;
        tick();
        tick();
        chk("reset", P_OFF, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_reset", P_OFF, 1'b0);

        // No-op in OFF, power-up, no-op in ON.
        noop(P_OFF);
        power_up();
        noop(P_ON);

        // Clean power-down, idle from the first drain cycle.
        pd_accept();
        pd_rest(16'hFFFF, 1'b0, 1'b0);

        // Idle glitch: 5 high, 1 low, then high.
        power_up();
        pd_accept();
        pd_rest(16'hFFDF, 1'b0, 1'b0);

        // Timeout with the clear in the same cycle as the set: flag stays.
        power_up();
        pd_accept();
        pd_rest(16'h0000, 1'b1, 1'b0);

        // Clean drain with a clear in its last cycle: flag drops.
        power_up();
        pd_accept();
        pd_rest(16'hFFFF, 1'b1, 1'b0);

        // Timeout, then clear in the first PD_RST cycle.
        power_up();
        pd_accept();
        pd_rest(16'h0000, 1'b0, 1'b1);

        // Idle completion coincides with the timeout: idle wins.
        power_up();
        pd_accept();
        pd_rest(16'hFF00, 1'b0, 1'b0);

        // Command held through PU_HOLD, accepted once ON.
        chk("held_pre", P_OFF, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_on    = 1'b1;
        tick();
        cmd_if.cmd_on = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            chk("held_pu", P_PU, 1'b0);
            tick();
        end
        chk("held_on", P_ON, 1'b1);
        tick();
        cmd_if.cmd_valid = 1'b0;
        pd_rest(16'hFFFF, 1'b0, 1'b0);

        // Reset in the middle of PU_HOLD.
        chk("rpu_pre", P_OFF, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_on    = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        span("rpu_hold", P_PU, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_pu", P_OFF, 1'b0);
        tick();

        // Leave the timeout flag set, then reset in the middle of PD_DRAIN.
        power_up();
        pd_accept();
        pd_rest(16'h0000, 1'b0, 1'b0);
        power_up();
        pd_accept();
        idle = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rdr_drain", P_DR, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        tmo_exp = 1'b0;
        chk("rst_mid_drain", P_OFF, 1'b0);
        tick();

        // Randomized traffic.
        cur_on = 1'b0;
        for (int it = 0; it < 30; it++) begin
            span("rnd_gap", cur_on ? P_ON : P_OFF, $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                noop(cur_on ? P_ON : P_OFF);
            end else if (!cur_on) begin
                power_up();
                cur_on = 1'b1;
            end else begin
                thr = $urandom_range(2, 10);
                for (int b = 0; b < 16; b++) begin
                    pat[b] = ($urandom_range(0, 9) < thr);
                end
                pd_accept();
                pd_rest(pat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                cur_on = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
